// File: rtl/exec_pkg.sv
// Execute-stage shared definitions: ALU op encoding and datapath width default.
package exec_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_SLT  = 3'b100,
    ALU_SLTU = 3'b101,
    ALU_XOR  = 3'b110,
    ALU_NOR  = 3'b111
  } alu_op_e;

endpackage

// File: rtl/exec_unit_alu.sv
// Combinational ALU for the execute stage.
// ALU_OVERFLOW_EN adds a signed add/sub overflow flag.
module alu
  import exec_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUop,
`ifdef ALU_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  assign sum  = A + B;
  assign diff = A - B;

  // Operation select; add/sub wrap silently
  always_comb begin
    result = '0;
    case (alu_op_e'(ALUop))
      ALU_ADD:  result = sum;
      ALU_SUB:  result = diff;
      ALU_AND:  result = A & B;
      ALU_OR:   result = A | B;
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (A < B)};
      ALU_XOR:  result = A ^ B;
      ALU_NOR:  result = ~(A | B);
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

`ifdef ALU_OVERFLOW_EN
  // Signed overflow: operands agree in sign (sub: B inverted) but result differs
  always_comb begin
    ovf = 1'b0;
    case (alu_op_e'(ALUop))
      ALU_ADD: ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1]  != A[WIDTH-1]);
      ALU_SUB: ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      default: ovf = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/exec_unit.sv
// Execute stage: operand mux, immediate extender, ALU, branch-target adder,
// destination select, all captured in one output register (latency 1).
// Optional feature macro: ALU_OVERFLOW_EN (adds registered ovf output).
module exec_unit
  import exec_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] PC,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  input  logic [31:0]      instr,
  input  logic [2:0]       ALUop,
  input  logic             ExtOp,
  input  logic             ALUSrc,
  input  logic             RegDst,
`ifdef ALU_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] ALUout,
  output logic             zero,
  output logic [WIDTH-1:0] Target,
  output logic [4:0]       Regout
);

  logic [15:0]      imm16;
  logic [WIDTH-1:0] imm_sext;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero;
  logic [WIDTH-1:0] tgt_nxt;
  logic [4:0]       dst_nxt;
`ifdef ALU_OVERFLOW_EN
  logic             alu_ovf;
`endif

  assign imm16    = instr[15:0];
  assign imm_sext = {{(WIDTH-16){imm16[15]}}, imm16};
  assign imm_ext  = ExtOp ? imm_sext : {{(WIDTH-16){1'b0}}, imm16};
  assign alu_b    = ALUSrc ? imm_ext : busB;
  // Branch target always uses sign extension, independent of ExtOp
  assign tgt_nxt  = PC + (imm_sext << 2);
  assign dst_nxt  = RegDst ? instr[15:11] : instr[20:16];

  alu #(.WIDTH(WIDTH)) u_alu (
    .A      (busA),
    .B      (alu_b),
    .ALUop  (ALUop),
`ifdef ALU_OVERFLOW_EN
    .ovf    (alu_ovf),
`endif
    .result (alu_res),
    .zero   (alu_zero)
  );

  // Output register; reset forces a zero result, so zero flag reads 1
  always_ff @(posedge clk) begin
    if (reset) begin
      ALUout <= '0;
      zero   <= 1'b1;
      Target <= '0;
      Regout <= '0;
`ifdef ALU_OVERFLOW_EN
      ovf    <= 1'b0;
`endif
    end else begin
      ALUout <= alu_res;
      zero   <= alu_zero;
      Target <= tgt_nxt;
      Regout <= dst_nxt;
`ifdef ALU_OVERFLOW_EN
      ovf    <= alu_ovf;
`endif
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: hand-computed vectors, one edge latency.
module tb_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC, busA, busB, instr;
  logic [2:0]  ALUop;
  logic        ExtOp, ALUSrc, RegDst;
  logic [31:0] ALUout, Target;
  logic        zero;
  logic [4:0]  Regout;
`ifdef ALU_OVERFLOW_EN
  logic        ovf;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exec_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .PC     (PC),
    .busA   (busA),
    .busB   (busB),
    .instr  (instr),
    .ALUop  (ALUop),
    .ExtOp  (ExtOp),
    .ALUSrc (ALUSrc),
    .RegDst (RegDst),
`ifdef ALU_OVERFLOW_EN
    .ovf    (ovf),
`endif
    .ALUout (ALUout),
    .zero   (zero),
    .Target (Target),
    .Regout (Regout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic base();
    ALUSrc = 1'b0; ExtOp = 1'b0; RegDst = 1'b0;
    busA = 32'd2; busB = 32'd8; PC = 32'd4; instr = 32'h0022_2028;
  endtask

  initial begin
    reset = 1'b1; ALUop = 3'b000;
    base();
    step();
    chk("rst_aluout", ALUout, 32'h0);
    chk("rst_zero",   {31'b0, zero}, 32'h1);
    chk("rst_target", Target, 32'h0);
    chk("rst_regout", {27'b0, Regout}, 32'h0);

    // Base vectors: step ALUop 000..100
    reset = 1'b0;
    ALUop = 3'b000; step();
    chk("add_out", ALUout, 32'd10);
    chk("add_zero", {31'b0, zero}, 32'h0);
    chk("base_regout", {27'b0, Regout}, 32'd2);
    chk("base_target", Target, 32'h0000_80A4);
    ALUop = 3'b001; step();
    chk("sub_out", ALUout, 32'hFFFF_FFFA);
    chk("sub_zero", {31'b0, zero}, 32'h0);
    ALUop = 3'b010; step();
    chk("and_out", ALUout, 32'h0);
    chk("and_zero", {31'b0, zero}, 32'h1);
    ALUop = 3'b011; step();
    chk("or_out", ALUout, 32'd10);
    chk("or_zero", {31'b0, zero}, 32'h0);
    ALUop = 3'b100; step();
    chk("slt_out", ALUout, 32'd1);
    chk("slt_zero", {31'b0, zero}, 32'h0);
    ALUop = 3'b110; step();
    chk("xor_out", ALUout, 32'h0000_000A);
    ALUop = 3'b111; step();
    chk("nor_out", ALUout, 32'hFFFF_FFF5);

    // Signed vs unsigned compare with a negative A
    busA = 32'hFFFF_FFFF; busB = 32'd1;
    ALUop = 3'b100; step();
    chk("slt_neg", ALUout, 32'd1);
    ALUop = 3'b101; step();
    chk("sltu_big", ALUout, 32'd0);
    chk("sltu_zero", {31'b0, zero}, 32'h1);
    // Wrap on add and sub
    ALUop = 3'b000; step();
    chk("add_wrap", ALUout, 32'h0);
    chk("add_wrap_zero", {31'b0, zero}, 32'h1);
    busA = 32'h0; ALUop = 3'b001; step();
    chk("sub_wrap", ALUout, 32'hFFFF_FFFF);

    // Immediate path and rd select
    base();
    RegDst = 1'b1; ALUSrc = 1'b1; ExtOp = 1'b0; ALUop = 3'b000;
    instr = 32'h0022_A028; step();
    chk("imm_regout", {27'b0, Regout}, 32'd20);
    chk("imm_zext", ALUout, 32'h0000_A02A);
    chk("imm_target", Target, 32'hFFFE_80A4);
    ExtOp = 1'b1; step();
    chk("imm_sext", ALUout, 32'hFFFF_A02A);

    // Backward branch target
    base();
    instr = 32'h0000_FFFF; PC = 32'h0000_0100; step();
    chk("tgt_back", Target, 32'h0000_00FC);

    // Inputs changing between edges must not disturb outputs
    base(); ALUop = 3'b000; step();
    chk("hold_pre", ALUout, 32'd10);
    busA = 32'd100; ALUop = 3'b001;
    #3;
    chk("hold_mid", ALUout, 32'd10);
    chk("hold_tgt", Target, 32'h0000_80A4);

    // Mid-stream reset discards the in-flight result
    base(); ALUop = 3'b000; reset = 1'b1; step();
    chk("mrst_aluout", ALUout, 32'h0);
    chk("mrst_zero", {31'b0, zero}, 32'h1);
    chk("mrst_target", Target, 32'h0);
    chk("mrst_regout", {27'b0, Regout}, 32'h0);
    reset = 1'b0; step();
    chk("resume_out", ALUout, 32'd10);
    chk("resume_target", Target, 32'h0000_80A4);
    chk("resume_regout", {27'b0, Regout}, 32'd2);

`ifdef ALU_OVERFLOW_EN
    busA = 32'h7FFF_FFFF; busB = 32'd1; ALUop = 3'b000; step();
    chk("ovf_add_out", ALUout, 32'h8000_0000);
    chk("ovf_add", {31'b0, ovf}, 32'h1);
    busA = 32'h8000_0000; ALUop = 3'b001; step();
    chk("ovf_sub", {31'b0, ovf}, 32'h1);
    ALUop = 3'b011; step();
    chk("ovf_or", {31'b0, ovf}, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter WIDTH, default 32, datapath width; all 32-bit buses below are WIDTH bits.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 PC  input  32  incremented PC (PC+4) of the instruction in execute.
REQ-006 busA  input  32  rs operand.
REQ-007 busB  input  32  rt operand.
REQ-008 instr  input  32  instruction word; [20:16] rt, [15:11] rd, [15:0] imm16.
REQ-009 ALUop  input  3  ALU operation select.
REQ-010 ExtOp  input  1  immediate extension: 1 sign, 0 zero.
REQ-011 ALUSrc  input  1  ALU B source: 0 busB, 1 extended imm16.
REQ-012 RegDst  input  1  destination select: 0 rt, 1 rd.
REQ-013 ALUout  output  32  registered ALU result.
REQ-014 zero  output  1  registered, 1 when the ALU result is all zeros.
REQ-015 Target  output  32  registered branch target.
REQ-016 Regout  output  5  registered destination register number.

Function
REQ-017 ALU B operand = busB when ALUSrc=0, else ext(imm16) per ExtOp.
REQ-018 ALUop encoding:
- 000 add
- 001 sub (A-B)
- 010 and
- 011 or
- 100 slt (signed, result 1 or 0)
- 101 sltu (unsigned)
- 110 xor
- 111 nor
REQ-019 add/sub wrap modulo 2^32; no trap.
REQ-020 zero = (ALU result == 0), computed from the same-cycle result.
REQ-021 Target = PC + (sign-extended imm16 << 2), always sign-extended regardless of ExtOp; wraps modulo 2^32.
REQ-022 Regout = instr[20:16] when RegDst=0, instr[15:11] when RegDst=1.
REQ-023 All outputs are registered: inputs sampled at a rising edge appear on outputs after that edge (latency 1 cycle, throughput 1 per cycle, no handshake, no stall).
REQ-024 Outputs change only on rising clk edges; input changes between edges have no output effect.

Reset
REQ-025 When reset=1 at a rising edge, ALUout, Target and Regout become 0 and zero becomes 1 (matching ALUout=0), overriding any inputs.
REQ-026 The first edge with reset=0 loads normal results; reset asserted mid-stream discards the in-flight result.

Configuration
REQ-027 With ALU_OVERFLOW_EN defined, add output ovf (1 bit, registered, reset 0): 1 when signed add or sub overflows, 0 for all other ops.
REQ-028 Without ALU_OVERFLOW_EN, the ovf port and its logic are absent; all other behaviour is identical.

Structure
REQ-029 Package exec_pkg holds the ALUop encoding constants and WIDTH default.
REQ-030 Combinational sub-module alu (A, B, ALUop -> result, zero[, ovf]); exec_unit holds the muxes, extender, target adder and output register.

Verification
REQ-031 In all scenarios below, with ALUSrc=0, ExtOp=0, RegDst=0, busA=2, busB=8, PC=4, instr=0x00222028, one edge after inputs are applied, Regout=2 and Target=0x000080A4.
REQ-032 Under REQ-031 inputs, step ALUop 000/001/010/011/100 per cycle -> ALUout 10, 0xFFFFFFFA, 0, 10, 1; zero 0,0,1,0,0.
REQ-033 RegDst=1, ALUSrc=1, ExtOp=0, ALUop=000, instr=0x0022A028 -> Regout=20, ALUout=0x0000A02A; with ExtOp=1 -> ALUout=0xFFFFA02A.
REQ-034 instr imm16=0xFFFF, PC=0x100 -> Target=0x000000FC.
REQ-035 Reset asserted for one edge mid-sequence -> ALUout=0, Target=0, Regout=0, zero=1; next edge resumes correct results.
REQ-036 ALU_OVERFLOW_EN defined, busA=0x7FFFFFFF, busB=1, ALUop=000 -> ALUout=0x80000000, ovf=1.
